// File: rtl/vehicle_detect_conditioner.sv
// Loop-sensor conditioner: per-direction synchroniser, debounce and request latch feeding the traffic controller.
// Optional wait-age counters / starved flags are built only when VDC_WAIT_AGE_EN is defined.

module vdc_channel #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_WAIT        = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor_raw,
  input  logic       served,
  output logic       vehicle_detect,
  output logic [4:0] wait_count,
  output logic       starved
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   synced_s;
  logic [DB_W-1:0]        db_cnt_r;
  logic [DB_W-1:0]        db_cnt_nxt_s;
  logic                   stable_r;
  logic                   stable_nxt_s;
  logic                   stable_d_r;
  logic                   rise_s;
  state_t                 state_r;
  state_t                 state_nxt_s;
  logic                   detect_r;

  // Input synchroniser chain for the asynchronous sensor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], sensor_raw};
    end
  end

  assign synced_s = sync_r[SYNC_STAGES-1];

  // Debounce: level changes only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    db_cnt_nxt_s = '0;
    stable_nxt_s = stable_r;
    if (synced_s != stable_r) begin
      if (db_cnt_r == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_nxt_s = synced_s;
        db_cnt_nxt_s = '0;
      end else begin
        db_cnt_nxt_s = db_cnt_r + DB_W'(1);
      end
    end else begin
      db_cnt_nxt_s = '0;
    end
  end

  // Debounce state and previous-level register used for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_r   <= '0;
      stable_r   <= 1'b0;
      stable_d_r <= 1'b0;
    end else begin
      db_cnt_r   <= db_cnt_nxt_s;
      stable_r   <= stable_nxt_s;
      stable_d_r <= stable_r;
    end
  end

  assign rise_s = stable_r & ~stable_d_r;

  // Request latch: served is ignored in IDLE, so a simultaneous rise still latches
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          state_nxt_s = PENDING;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PENDING: begin
        if (served) begin
          if (stable_r) begin
            state_nxt_s = SERVING;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = PENDING;
        end
      end
      SERVING: begin
        if (!stable_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SERVING;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register and registered request output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      detect_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      detect_r <= (state_nxt_s == PENDING);
    end
  end

  assign vehicle_detect = detect_r;

`ifdef VDC_WAIT_AGE_EN
  logic [4:0] wait_r;
  logic [4:0] wait_nxt_s;
  logic       starved_r;

  // Age is 0 on the first PENDING cycle and counts up while the request stays latched
  always_comb begin
    wait_nxt_s = 5'd0;
    if ((state_r == PENDING) && (state_nxt_s == PENDING)) begin
      if (wait_r == 5'(MAX_WAIT)) begin
        wait_nxt_s = wait_r;
      end else begin
        wait_nxt_s = wait_r + 5'd1;
      end
    end else begin
      wait_nxt_s = 5'd0;
    end
  end

  // Wait-age counter and starved flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_r    <= 5'd0;
      starved_r <= 1'b0;
    end else begin
      wait_r    <= wait_nxt_s;
      starved_r <= (wait_nxt_s == 5'(MAX_WAIT));
    end
  end

  assign wait_count = wait_r;
  assign starved    = starved_r;
`else
  assign wait_count = 5'd0;
  assign starved    = 1'b0;
`endif

endmodule

module vehicle_detect_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_WAIT        = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ns_sensor_raw,
  input  logic       ew_sensor_raw,
  input  logic       ns_served,
  input  logic       ew_served,
  output logic       ns_vehicle_detect,
  output logic       ew_vehicle_detect,
  output logic [4:0] ns_wait_count,
  output logic [4:0] ew_wait_count,
  output logic       ns_starved,
  output logic       ew_starved
);

  vdc_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .MAX_WAIT       (MAX_WAIT)
  ) u_ns (
    .clk           (clk),
    .rst_n         (rst_n),
    .sensor_raw    (ns_sensor_raw),
    .served        (ns_served),
    .vehicle_detect(ns_vehicle_detect),
    .wait_count    (ns_wait_count),
    .starved       (ns_starved)
  );

  vdc_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .MAX_WAIT       (MAX_WAIT)
  ) u_ew (
    .clk           (clk),
    .rst_n         (rst_n),
    .sensor_raw    (ew_sensor_raw),
    .served        (ew_served),
    .vehicle_detect(ew_vehicle_detect),
    .wait_count    (ew_wait_count),
    .starved       (ew_starved)
  );

endmodule
